mw_arith_seq: RTL and testbench
===============================

// Module: mw_arith_seq
// PURPOSE
//  Multi-word sequencer upstream of the 8-bit arithmetic unit. Accepts one wide command, issues it word by word (LS word first).
//  Chains carry/borrow through the unit's carry_in/carry_out. Returns the assembled wide result over a valid/ready response.
// PARAMETERS
//  DATA_W   8   width of one arithmetic-unit word
//  WORDS    4   words per operand (operand width = DATA_W*WORDS), >=1
//  OP_W     3   width of cmd_op and alu_op
// PORTS
//  clk          in   1             rising-edge clock
//  rst          in   1             asynchronous, active-high reset
//  cmd_valid    in   1             command present
//  cmd_ready    out  1             sequencer can accept a command
//  cmd_op       in   OP_W          000 ADD,001 ADC,010 SUB,011 SBB,100 INC,101 DEC,11x reserved
//  cmd_a        in   DATA_W*WORDS  operand A
//  cmd_b        in   DATA_W*WORDS  operand B (ignored for INC/DEC)
//  cmd_cin      in   1             carry/borrow in (ADC/SBB only)
//  rsp_valid    out  1             response present
//  rsp_ready    in   1             consumer takes response
//  rsp_result   out  DATA_W*WORDS  wide result
//  rsp_cout     out  1             final carry (add) / borrow (sub)
//  rsp_zero     out  1             rsp_result == 0
//  alu_op       out  OP_W          to arithmetic unit op_code
//  alu_a        out  DATA_W        to arithmetic unit a_in
//  alu_b        out  DATA_W        to arithmetic unit b_in
//  alu_cin      out  1             to arithmetic unit carry_in
//  alu_result   in   DATA_W        from arithmetic unit result_out (combinational path)
//  alu_cout     in   1             from arithmetic unit carry_out
// BEHAVIOUR
//  - FSM IDLE -> RUN -> DONE -> IDLE. Reset: state IDLE, idx 0, carry/result/operand regs 0.
//  - cmd_ready = (state==IDLE) & ~rst; rsp_valid = (state==DONE); outputs 0 during reset.
//  - IDLE: on cmd_valid&cmd_ready latch op/a/b/cin, idx<=0, ->RUN. No other command accepted until back in IDLE.
//  - RUN: drive word idx of latched a/b combinationally; each edge store alu_result into result word idx, alu_cout into carry reg.
//    idx==WORDS-1 -> DONE, else idx++.
//  - Word-0 alu_op/alu_cin: ADD 001/0, ADC 010/cmd_cin, SUB 011/0, SBB 100/cmd_cin, INC 101/0, DEC 110/0; reserved -> 111 (unit yields 0).
//  - Words>0: ADD/ADC/INC -> 010 with cin=carry reg; SUB/SBB/DEC -> 100 with cin=carry reg; reserved -> 111.
//  - INC/DEC force alu_b=0 on every word. IDLE/DONE: alu_op=000, alu_a=alu_b=0, alu_cin=0.
//  - Latency: rsp_valid rises WORDS cycles after the accept edge. Throughput: one command per WORDS+2 cycles with rsp_ready=1.
//  - DONE: rsp_* held stable until rsp_valid&rsp_ready; then ->IDLE. rsp_cout = carry reg after the last word.
//  - Reserved ops: accepted, same latency, result 0, cout 0, zero 1. WORDS==1: RUN lasts exactly one cycle.
//  - rst asserted anywhere (incl. mid-RUN): immediate return to reset state; partial results are discarded.
// CONFIGURATION
//  - MW_ARITH_OVF_EN defined: adds output port rsp_ovf (1 bit, reset 0), the signed overflow of the wide operation.
//    Computed from the top-word msbs: add class (a^r)&(b^r); sub class (a^b)&(a^r); INC/DEC use b=0; reserved 0.
//    rsp_ovf is held with the other rsp_* signals.
//  - Undefined: no rsp_ovf port and no overflow logic.
// STRUCTURE
//  - Package mw_arith_pkg: cmd op codes, alu op codes (PASS..DEC, ZERO=111), FSM state encoding.
//  - Sub-module mw_arith_op_decode (combinational): (cmd_op, first_word) -> alu_op, b_zero, cin_sel.
// TESTING (WORDS=4, DATA_W=8)
//  - ADD a=0x000000FF b=0x00000001 -> result 0x00000100, cout 0, zero 0; rsp_valid 4 cycles after accept.
//  - SUB a=0x00000000 b=0x00000001 -> result 0xFFFFFFFF, cout 1.
//  - ADC a=0xFFFFFFFF b=0 cin=1 -> result 0x00000000, cout 1, zero 1. DEC a=0x00010000 -> 0x0000FFFF, cout 0.
//  - rsp_ready low 5 cycles: rsp_* stable, cmd_ready 0 and a held cmd_valid is not taken; accepted 1 cycle after the response handshake.
//  - rst pulse at RUN idx 2: all outputs 0 at once; next ADD 0x12345678+0x11111111 -> 0x23456789.
//  - MW_ARITH_OVF_EN: ADD 0x7FFFFFFF+1 -> ovf 1; SUB 0x80000000-1 -> ovf 1; ADD 1+1 -> ovf 0.

Source files
------------

// File: rtl/mw_arith_pkg.sv
// Shared encodings for the multi-word arithmetic sequencer: command ops, unit ops, FSM states.
// Pure constants; no logic, no latency, no flow control.
package mw_arith_pkg;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_ADC = 3'b001;
    localparam logic [2:0] CMD_SUB = 3'b010;
    localparam logic [2:0] CMD_SBB = 3'b011;
    localparam logic [2:0] CMD_INC = 3'b100;
    localparam logic [2:0] CMD_DEC = 3'b101;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_ADC  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_SBB  = 3'b100;
    localparam logic [2:0] ALU_INC  = 3'b101;
    localparam logic [2:0] ALU_DEC  = 3'b110;
    localparam logic [2:0] ALU_ZERO = 3'b111;

    typedef logic [1:0] cin_sel_t;
    localparam cin_sel_t CIN_ZERO  = 2'd0;
    localparam cin_sel_t CIN_CMD   = 2'd1;
    localparam cin_sel_t CIN_CARRY = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mw_arith_op_decode.sv
// Maps a wide command op plus word position onto the unit op, b-forcing and carry-in source.
// Combinational, zero latency; no flow control.
module mw_arith_op_decode
    import mw_arith_pkg::*;
(
    input  logic [2:0] cmd_op,
    input  logic       first_word,
    output logic [2:0] alu_op,
    output logic       b_zero,
    output cin_sel_t   cin_sel
);

    always_comb begin
        alu_op  = ALU_ZERO;
        b_zero  = 1'b0;
        cin_sel = CIN_ZERO;
        case (cmd_op)
            CMD_ADD: begin
                alu_op  = first_word ? ALU_ADD : ALU_ADC;
                cin_sel = first_word ? CIN_ZERO : CIN_CARRY;
            end
            CMD_ADC: begin
                alu_op  = ALU_ADC;
                cin_sel = first_word ? CIN_CMD : CIN_CARRY;
            end
            CMD_SUB: begin
                alu_op  = first_word ? ALU_SUB : ALU_SBB;
                cin_sel = first_word ? CIN_ZERO : CIN_CARRY;
            end
            CMD_SBB: begin
                alu_op  = ALU_SBB;
                cin_sel = first_word ? CIN_CMD : CIN_CARRY;
            end
            // Upper words of INC/DEC just ripple the carry/borrow against b=0
            CMD_INC: begin
                alu_op  = first_word ? ALU_INC : ALU_ADC;
                b_zero  = 1'b1;
                cin_sel = first_word ? CIN_ZERO : CIN_CARRY;
            end
            CMD_DEC: begin
                alu_op  = first_word ? ALU_DEC : ALU_SBB;
                b_zero  = 1'b1;
                cin_sel = first_word ? CIN_ZERO : CIN_CARRY;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mw_arith_seq.sv
// Issues one wide arithmetic command word by word (LS first) through an external 8-bit unit, chaining carry.
// Response valid WORDS cycles after accept; one command per WORDS+2 cycles; rsp held until rsp_ready.
// Optional MW_ARITH_OVF_EN adds rsp_ovf (signed overflow of the wide operation).
module mw_arith_seq
    import mw_arith_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WORDS  = 4,
    parameter int OP_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OP_W-1:0]         cmd_op,
    input  logic [DATA_W*WORDS-1:0] cmd_a,
    input  logic [DATA_W*WORDS-1:0] cmd_b,
    input  logic                    cmd_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W*WORDS-1:0] rsp_result,
    output logic                    rsp_cout,
    output logic                    rsp_zero,
`ifdef MW_ARITH_OVF_EN
    output logic                    rsp_ovf,
`endif
    output logic [OP_W-1:0]         alu_op,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic                    alu_cin,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    alu_cout
);

    localparam int TOT_W = DATA_W * WORDS;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [OP_W-1:0]  op_q;
    logic [TOT_W-1:0] a_q;
    logic [TOT_W-1:0] b_q;
    logic             cin_q;
    logic             carry_q;
    logic [TOT_W-1:0] result_q;

    logic [2:0]  dec_op;
    logic        dec_b_zero;
    cin_sel_t    dec_cin_sel;

    mw_arith_op_decode u_decode (
        .cmd_op     (op_q[2:0]),
        .first_word (idx == '0),
        .alu_op     (dec_op),
        .b_zero     (dec_b_zero),
        .cin_sel    (dec_cin_sel)
    );

    assign cmd_ready  = (state == ST_IDLE) & ~rst;
    assign rsp_valid  = (state == ST_DONE);
    assign rsp_result = result_q;
    assign rsp_cout   = carry_q;
    assign rsp_zero   = rsp_valid & (result_q == '0);

    always_comb begin
        alu_op  = '0;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        if (state == ST_RUN) begin
            alu_op = OP_W'(dec_op);
            alu_a  = a_q[int'(idx)*DATA_W +: DATA_W];
            alu_b  = dec_b_zero ? '0 : b_q[int'(idx)*DATA_W +: DATA_W];
            case (dec_cin_sel)
                CIN_CMD:   alu_cin = cin_q;
                CIN_CARRY: alu_cin = carry_q;
                default:   alu_cin = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q  <= cmd_op;
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        cin_q <= cmd_cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q[int'(idx)*DATA_W +: DATA_W] <= alu_result;
                    carry_q <= alu_cout;
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MW_ARITH_OVF_EN
    logic a_msb, b_msb, r_msb, ovf;
    assign a_msb = a_q[TOT_W-1];
    assign b_msb = b_q[TOT_W-1];
    assign r_msb = result_q[TOT_W-1];

    // INC/DEC behave as add/sub against an all-zero b operand
    always_comb begin
        ovf = 1'b0;
        case (op_q[2:0])
            CMD_ADD, CMD_ADC: ovf = (a_msb ^ r_msb) & (b_msb ^ r_msb);
            CMD_SUB, CMD_SBB: ovf = (a_msb ^ b_msb) & (a_msb ^ r_msb);
            CMD_INC:          ovf = (a_msb ^ r_msb) & r_msb;
            CMD_DEC:          ovf = a_msb & (a_msb ^ r_msb);
            default:          ovf = 1'b0;
        endcase
    end
    assign rsp_ovf = rsp_valid & ovf;
`endif

endmodule

// File: tb/tb_mw_arith_seq.sv
// Directed bench for mw_arith_seq (WORDS=4, DATA_W=8) with a behavioural model of the 8-bit unit.
module tb_mw_arith_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        cmd_cin = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_zero;
`ifdef MW_ARITH_OVF_EN
    logic        rsp_ovf;
`endif
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [7:0]  alu_result;
    logic        alu_cout;

    always #5 clk = ~clk;

    mw_arith_seq #(.DATA_W(8), .WORDS(4), .OP_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_cin    (cmd_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_zero   (rsp_zero),
`ifdef MW_ARITH_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    // 8-bit arithmetic unit: cout is carry for adds, borrow for subtracts
    logic [8:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (alu_op)
            3'd0: alu_t = {1'b0, alu_a};
            3'd1: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
            3'd2: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            3'd3: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
            3'd4: alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
            3'd5: alu_t = {1'b0, alu_a} + 9'd1;
            3'd6: alu_t = {1'b0, alu_a} - 9'd1;
            default: alu_t = '0;
        endcase
    end
    assign alu_result = alu_t[7:0];
    assign alu_cout   = alu_t[8];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic        cout;
        logic        zero;
        logic        ovf;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int lat;
        @(negedge clk);
        cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_cin = v.cin;
        cmd_valid = 1'b1;
        lat = 0;
        while (!cmd_ready && lat < 50) begin @(negedge clk); lat++; end
        chk($sformatf("v%0d_accept", i), 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
        chk($sformatf("v%0d_result", i), 64'(rsp_result), 64'(v.res));
        chk($sformatf("v%0d_cout", i), 64'(rsp_cout), 64'(v.cout));
        chk($sformatf("v%0d_zero", i), 64'(rsp_zero), 64'(v.zero));
`ifdef MW_ARITH_OVF_EN
        chk($sformatf("v%0d_ovf", i), 64'(rsp_ovf), 64'(v.ovf));
`endif
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        //          op      a             b             cin   result        cout  zero  ovf
        vecs[0]  = '{3'b000, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b010, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'b101, 32'h00010000, 32'hDEADBEEF, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFFFFFF, 32'h12345678, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{3'b011, 32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b110, 32'h12345678, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'b000, 32'h00000001, 32'h00000002, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b010, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'b010, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b000, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Response backpressure: a pending command must wait for the handshake
        run_vec(100, vecs[0]);
        @(negedge clk);
        cmd_op = 3'b000; cmd_a = 32'h000000FF; cmd_b = 32'h00000001; cmd_cin = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_first_valid", 64'(rsp_valid), 64'd1);
        cmd_op = 3'b000; cmd_a = 32'h00000001; cmd_b = 32'h00000001;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", k), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp_result_%0d", k), 64'(rsp_result), 64'h100);
            chk($sformatf("bp_cmd_ready_%0d", k), 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_idle_ready", 64'(cmd_ready), 64'd1);
        chk("bp_idle_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_taken", 64'(cmd_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_second_valid", 64'(rsp_valid), 64'd1);
        chk("bp_second_result", 64'(rsp_result), 64'd2);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset in the middle of RUN
        @(negedge clk);
        cmd_op = 3'b000; cmd_a = 32'hFFFFFFFF; cmd_b = 32'h00000001; cmd_cin = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("run_w0_op", 64'(alu_op), 64'd1);
        chk("run_w0_a", 64'(alu_a), 64'hFF);
        @(posedge clk); #1;
        chk("run_w1_op", 64'(alu_op), 64'd2);
        chk("run_w1_cin", 64'(alu_cin), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
        chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
        chk("mid_rst_alu_b", 64'(alu_b), 64'd0);
        chk("mid_rst_alu_cin", 64'(alu_cin), 64'd0);
        chk("mid_rst_result", 64'(rsp_result), 64'd0);
        chk("mid_rst_cout", 64'(rsp_cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        vecs[0] = '{3'b000, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
        run_vec(200, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
